// File: rtl/tbuf_rd_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tbuf_rd_arbiter_if : requester and token-buffer read-port bundle         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface tbuf_rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 1024
);
    logic [NUM_REQ-1:0]        req_rd_en;
    logic [NUM_REQ*ADDR_W-1:0] req_rd_addr;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        req_rd_valid;
    logic [DATA_W-1:0]         req_rd_data;
    logic                      tbuf_rd_en;
    logic [ADDR_W-1:0]         tbuf_rd_addr;
    logic [DATA_W-1:0]         tbuf_rd_data;
    logic                      tbuf_rd_valid;

    // master = the arbiter; slave = requesters plus token buffer
    modport master (
        input  req_rd_en, req_rd_addr, tbuf_rd_data, tbuf_rd_valid,
        output req_gnt, req_rd_valid, req_rd_data, tbuf_rd_en, tbuf_rd_addr
    );
    modport slave (
        output req_rd_en, req_rd_addr, tbuf_rd_data, tbuf_rd_valid,
        input  req_gnt, req_rd_valid, req_rd_data, tbuf_rd_en, tbuf_rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/tbuf_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tbuf_rd_arbiter : round-robin token-buffer read arbiter, in-order ID FIFO |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tbuf_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 1024,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    tbuf_rd_arbiter_if.master   bus,
    output logic                busy,
    output logic                err_spurious
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W:0]   c_num_req  = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]   fifo_q [2**IDX_W];
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic               tbuf_en_q;
    logic [ADDR_W-1:0]  tbuf_addr_q;
    logic               err_q;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_win_vld;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_head;
    logic               w_push, w_pop, w_spur;

    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W:0] sum);
        logic [PTR_W:0] v;
        v = (sum >= c_num_req) ? (sum - c_num_req) : sum;
        return v[PTR_W-1:0];
    endfunction

    // A requester whose grant pulse is high is masked so it cannot win twice
    assign w_elig = bus.req_rd_en & ~gnt_q;

    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        if (cnt_q < c_cnt_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = f_wrap({1'b0, rr_ptr_q} + (PTR_W + 1)'(k));
                if (!w_win_vld && w_elig[w_cand]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = w_cand;
                end
            end
        end
    end

    assign w_head = fifo_q[rd_ptr_q];
    assign w_push = w_win_vld;
    assign w_pop  = bus.tbuf_rd_valid && (cnt_q != '0);
    assign w_spur = bus.tbuf_rd_valid && (cnt_q == '0);

    always_comb begin
        gnt_d      = '0;
        rd_valid_d = '0;
        if (w_push) gnt_d[w_win_idx] = 1'b1;
        if (w_pop)  rd_valid_d[w_head] = 1'b1;
        rr_ptr_d = w_push ? f_wrap({1'b0, w_win_idx} + (PTR_W + 1)'(1)) : rr_ptr_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gnt_q       <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            tbuf_en_q   <= 1'b0;
            tbuf_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            tbuf_en_q  <= w_push;
            if (w_push) begin
                wr_ptr_q    <= wr_ptr_q + IDX_W'(1);
                tbuf_addr_q <= bus.req_rd_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
            end
            if (w_pop) begin
                rd_ptr_q  <= rd_ptr_q + IDX_W'(1);
                rd_data_q <= bus.tbuf_rd_data;
            end
            if (w_spur) err_q <= 1'b1;
        end
    end

    // ID storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_push) fifo_q[wr_ptr_q] <= w_win_idx;
    end

    assign bus.req_gnt      = gnt_q;
    assign bus.req_rd_valid = rd_valid_q;
    assign bus.req_rd_data  = rd_data_q;
    assign bus.tbuf_rd_en   = tbuf_en_q;
    assign bus.tbuf_rd_addr = tbuf_addr_q;
    assign busy             = (cnt_q != '0);
    assign err_spurious     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_tbuf_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tbuf_rd_arbiter : directed table plus randomized run against a model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tbuf_rd_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 1024;
    localparam int MAX_OUTST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, err_spurious;

    tbuf_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    tbuf_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: outstanding IDs kept as a plain queue of requester numbers
    int                 m_rr = 0;
    int                 m_q[$];
    logic [NUM_REQ-1:0] e_gnt = '0, e_rv = '0;
    logic [DATA_W-1:0]  e_rd = '0;
    logic               e_ten = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [ADDR_W-1:0]  e_taddr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low64 %h expected low64 %h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
        end
    endtask

    task automatic model_step();
        int w;
        int i;
        int h;
        if (!rst_n) begin
            m_rr = 0; m_q.delete();
            e_gnt = '0; e_rv = '0; e_rd = '0; e_ten = 1'b0; e_taddr = '0;
            e_busy = 1'b0; e_err = 1'b0;
        end else begin
            w = -1;
            if (m_q.size() < MAX_OUTST)
                for (int k = 0; k < NUM_REQ; k++) begin
                    i = (m_rr + k) % NUM_REQ;
                    if (w < 0 && bus.req_rd_en[i] && !e_gnt[i]) w = i;
                end
            e_rv = '0;
            if (bus.tbuf_rd_valid) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    e_rv = NUM_REQ'(1 << h);
                    e_rd = bus.tbuf_rd_data;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (w >= 0) begin
                e_gnt = NUM_REQ'(1 << w);
                e_ten = 1'b1;
                e_taddr = bus.req_rd_addr[w*ADDR_W +: ADDR_W];
                m_q.push_back(w);
                m_rr = (w + 1) % NUM_REQ;
            end else begin
                e_gnt = '0;
                e_ten = 1'b0;
            end
            e_busy = (m_q.size() != 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("m_gnt", 64'(bus.req_gnt), 64'(e_gnt));
        chk("m_rvalid", 64'(bus.req_rd_valid), 64'(e_rv));
        chk_data("m_rdata", bus.req_rd_data, e_rd);
        chk("m_ten", 64'(bus.tbuf_rd_en), 64'(e_ten));
        chk("m_taddr", 64'(bus.tbuf_rd_addr), 64'(e_taddr));
        chk("m_busy", 64'(busy), 64'(e_busy));
        chk("m_err", 64'(err_spurious), 64'(e_err));
    endtask

    typedef struct {
        logic               rst_n;
        logic [NUM_REQ-1:0] en;
        logic               tv;
        logic [7:0]         tdb;
        logic [NUM_REQ-1:0] gnt, rv;
        logic [7:0]         rdb;
        logic               ten;
        logic [7:0]         taddr;
        logic               busy, err;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] en, logic tv, logic [7:0] tdb, logic [3:0] g,
                                logic [3:0] rv, logic [7:0] rdb, logic ten, logic [7:0] ta,
                                logic b, logic e);
        vec_t v;
        v.rst_n = r; v.en = en; v.tv = tv; v.tdb = tdb; v.gnt = g; v.rv = rv;
        v.rdb = rdb; v.ten = ten; v.taddr = ta; v.busy = b; v.err = e;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int j = 0; j < DATA_W/32; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    typedef struct { int due; logic [DATA_W-1:0] d; } ret_t;

    vec_t              tab[$];
    ret_t              bq[$];
    ret_t              rr;
    int                last_due;
    bit                act[NUM_REQ];
    bit                gseen[NUM_REQ];
    logic [ADDR_W-1:0] raddr[NUM_REQ];

    initial begin
        bus.req_rd_en = '0; bus.req_rd_addr = '0;
        bus.tbuf_rd_valid = 1'b0; bus.tbuf_rd_data = '0;

        // requester addresses: r0=20 r1=21 r2=10 r3=23
        //          rst en    tv tdb    gnt   rv    rdb  ten ta   busy err
        tab.push_back(mk(0, 4'h0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 8'h00, 0, 0));
        tab.push_back(mk(1, 4'h4, 0, 8'h00, 4'h4, 4'h0, 8'h00, 1, 8'h10, 1, 0));
        tab.push_back(mk(1, 4'h4, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 8'h10, 1, 0));
        tab.push_back(mk(1, 4'h0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 8'h10, 1, 0));
        tab.push_back(mk(1, 4'h0, 1, 8'hAB, 4'h0, 4'h4, 8'hAB, 0, 8'h10, 0, 0));
        tab.push_back(mk(1, 4'h0, 0, 8'h00, 4'h0, 4'h0, 8'hAB, 0, 8'h10, 0, 0));
        tab.push_back(mk(1, 4'h0, 1, 8'h55, 4'h0, 4'h0, 8'hAB, 0, 8'h10, 0, 1));
        tab.push_back(mk(1, 4'h0, 0, 8'h00, 4'h0, 4'h0, 8'hAB, 0, 8'h10, 0, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h8, 4'h0, 8'hAB, 1, 8'h23, 1, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h1, 4'h0, 8'hAB, 1, 8'h20, 1, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h2, 4'h0, 8'hAB, 1, 8'h21, 1, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h4, 4'h0, 8'hAB, 1, 8'h10, 1, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h0, 4'h0, 8'hAB, 0, 8'h10, 1, 1));
        tab.push_back(mk(1, 4'hF, 1, 8'hC1, 4'h0, 4'h8, 8'hC1, 0, 8'h10, 1, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h8, 4'h0, 8'hC1, 1, 8'h23, 1, 1));
        tab.push_back(mk(1, 4'h0, 1, 8'hD0, 4'h0, 4'h1, 8'hD0, 0, 8'h23, 1, 1));
        tab.push_back(mk(1, 4'h0, 1, 8'hD1, 4'h0, 4'h2, 8'hD1, 0, 8'h23, 1, 1));
        tab.push_back(mk(1, 4'h1, 1, 8'hD2, 4'h1, 4'h4, 8'hD2, 1, 8'h20, 1, 1));
        tab.push_back(mk(1, 4'h0, 1, 8'hE3, 4'h0, 4'h8, 8'hE3, 0, 8'h20, 1, 1));
        tab.push_back(mk(1, 4'h0, 1, 8'hE0, 4'h0, 4'h1, 8'hE0, 0, 8'h20, 0, 1));
        tab.push_back(mk(1, 4'hE, 0, 8'h00, 4'h2, 4'h0, 8'hE0, 1, 8'h21, 1, 1));
        tab.push_back(mk(1, 4'hE, 0, 8'h00, 4'h4, 4'h0, 8'hE0, 1, 8'h10, 1, 1));
        tab.push_back(mk(1, 4'hE, 0, 8'h00, 4'h8, 4'h0, 8'hE0, 1, 8'h23, 1, 1));
        tab.push_back(mk(0, 4'h0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 8'h00, 0, 0));
        tab.push_back(mk(1, 4'h0, 1, 8'h77, 4'h0, 4'h0, 8'h00, 0, 8'h00, 0, 1));
        tab.push_back(mk(1, 4'hF, 0, 8'h00, 4'h1, 4'h0, 8'h00, 1, 8'h20, 1, 1));

        bus.req_rd_addr = 32'h23_10_21_20;
        foreach (tab[n]) begin
            rst_n = tab[n].rst_n;
            bus.req_rd_en = tab[n].en;
            bus.tbuf_rd_valid = tab[n].tv;
            bus.tbuf_rd_data = {128{tab[n].tdb}};
            cycle();
            chk($sformatf("row%0d_gnt", n), 64'(bus.req_gnt), 64'(tab[n].gnt));
            chk($sformatf("row%0d_rvalid", n), 64'(bus.req_rd_valid), 64'(tab[n].rv));
            chk_data($sformatf("row%0d_rdata", n), bus.req_rd_data, {128{tab[n].rdb}});
            chk($sformatf("row%0d_ten", n), 64'(bus.tbuf_rd_en), 64'(tab[n].ten));
            chk($sformatf("row%0d_taddr", n), 64'(bus.tbuf_rd_addr), 64'(tab[n].taddr));
            chk($sformatf("row%0d_busy", n), 64'(busy), 64'(tab[n].busy));
            chk($sformatf("row%0d_err", n), 64'(err_spurious), 64'(tab[n].err));
        end

        // randomized traffic: contract-following requesters, in-order buffer with latency 1..4
        last_due = cyc;
        for (int i = 0; i < NUM_REQ; i++) begin act[i] = 0; gseen[i] = 0; raddr[i] = '0; end
        for (int t = 0; t < 3000; t++) begin
            if (bus.tbuf_rd_en === 1'b1) begin
                rr.due = cyc + int'($urandom_range(1, 4));
                if (rr.due <= last_due) rr.due = last_due + 1;
                rr.d = rand_line();
                last_due = rr.due;
                bq.push_back(rr);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_gnt[i] === 1'b1) begin
                    gseen[i] = 1;
                end else if (gseen[i]) begin
                    gseen[i] = 0;
                    act[i] = ($urandom_range(0, 1) == 0);
                    raddr[i] = ADDR_W'($urandom());
                end else if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1;
                    raddr[i] = ADDR_W'($urandom());
                end
                bus.req_rd_en[i] = act[i];
                bus.req_rd_addr[i*ADDR_W +: ADDR_W] = raddr[i];
            end
            if (bq.size() > 0 && bq[0].due <= cyc) begin
                rr = bq.pop_front();
                bus.tbuf_rd_valid = 1'b1;
                bus.tbuf_rd_data = rr.d;
            end else begin
                bus.tbuf_rd_valid = 1'b0;
                bus.tbuf_rd_data = rand_line();
            end
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end

        // drain all outstanding reads, bounded
        rst_n = 1'b1;
        bus.req_rd_en = '0;
        for (int t = 0; t < 60 && (bq.size() > 0 || busy !== 1'b0); t++) begin
            if (bus.tbuf_rd_en === 1'b1) begin
                rr.due = (cyc + 1 > last_due) ? cyc + 1 : last_due + 1;
                rr.d = rand_line();
                last_due = rr.due;
                bq.push_back(rr);
            end
            if (bq.size() > 0 && bq[0].due <= cyc) begin
                rr = bq.pop_front();
                bus.tbuf_rd_valid = 1'b1;
                bus.tbuf_rd_data = rr.d;
            end else begin
                bus.tbuf_rd_valid = 1'b0;
            end
            cycle();
        end
        chk("drain_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tbuf_rd_arbiter.md
# tbuf_rd_arbiter

Round-robin arbiter that shares the single token-buffer read port between several activation/weight dispatchers. It accepts level-held read requests, issues at most one token-buffer read per cycle, and tracks outstanding reads in an in-order ID FIFO. It routes each returned 1024-bit line back to the requester that issued it. It sits between the dispatchers' `tbuf_rd_*` ports and the on-chip token buffer.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: token-buffer address width.
- `DATA_W`, 1024: token-buffer line width.
- `MAX_OUTST`, 4: maximum outstanding reads; ID FIFO depth (power of 2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_rd_en`  in  NUM_REQ  per-requester read request; held until granted.
- `req_rd_addr`  in  NUM_REQ*ADDR_W  request address; requester i uses slice [i*ADDR_W +: ADDR_W]; held with its request.
- `req_gnt`  out  NUM_REQ  one-hot, one-cycle grant pulse.
- `req_rd_valid`  out  NUM_REQ  one-hot, one-cycle data-return strobe.
- `req_rd_data`  out  DATA_W  returned line, broadcast to all requesters; qualified by `req_rd_valid`.
- `tbuf_rd_en`  out  1  token-buffer read strobe.
- `tbuf_rd_addr`  out  ADDR_W  token-buffer read address.
- `tbuf_rd_data`  in  DATA_W  token-buffer read data.
- `tbuf_rd_valid`  in  1  token-buffer data valid; returns arrive in issue order, with latency of 1 or more cycles.
- `busy`  out  1  high when one or more reads are outstanding.
- `err_spurious`  out  1  sticky flag: `tbuf_rd_valid` arrived with no read outstanding.

## Operation
- Registered state:
  - round-robin pointer `rr_ptr` (log2 NUM_REQ bits);
  - outstanding count `cnt` (0..MAX_OUTST);
  - ID FIFO with MAX_OUTST entries and wrapping read/write pointers;
  - `gnt_q`, which is `req_gnt` as registered.
- Eligibility, evaluated every cycle: requester i is eligible when `req_rd_en[i]=1` and `gnt_q[i]=0`. Masking a requester whose grant pulse is currently high prevents a double grant while it drops its request.
- Arbitration:
  - It is performed only when `cnt < MAX_OUTST`.
  - The winner is the first eligible index searching from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - There is no same-cycle credit from a pop: a full FIFO blocks grants even if `tbuf_rd_valid` is high that cycle.
- On a win by requester w, at the next edge:
  - `req_gnt <= onehot(w)`.
  - `tbuf_rd_en <= 1`.
  - `tbuf_rd_addr <= req_rd_addr` slice w.
  - Push w into the FIFO.
  - `rr_ptr <= (w+1) mod NUM_REQ`.
- With no winner, `req_gnt <= 0` and `tbuf_rd_en <= 0`. `tbuf_rd_addr` holds its last value.
- Return path, when `tbuf_rd_valid=1` with `cnt>0`, at the next edge:
  - pop the FIFO head h;
  - `req_rd_valid <= onehot(h)`;
  - `req_rd_data <= tbuf_rd_data`.
  
  Otherwise `req_rd_valid <= 0` and `req_rd_data` holds.
- Spurious return: `tbuf_rd_valid=1` with `cnt=0` sets `err_spurious`. There is no pop, nothing is delivered, and the flag clears only on reset.
- Counter update at each edge: push only gives `cnt+1`; pop only gives `cnt-1`; push and pop together leave `cnt` unchanged.
- `busy` is `cnt != 0`, driven combinationally from the register.
- Requester contract: hold `req_rd_en` and the address stable until `req_gnt[i]` is seen, then deassert on the following edge. Reasserting immediately is legal, and the arbiter may grant again at the earliest one cycle after the pulse ends.

## Timing
- Reset (`rst_n=0` at a rising edge) clears:
  - `req_gnt=0`, `req_rd_valid=0`, `req_rd_data=0`;
  - `tbuf_rd_en=0`, `tbuf_rd_addr=0`;
  - `busy=0`, `err_spurious=0`;
  - `rr_ptr=0`, `cnt=0`, and both FIFO pointers to 0.
  
  A reset mid-operation discards all outstanding IDs. Returns arriving after reset count as spurious.
- Grant latency: a request sampled high in cycle t, with the FIFO not full, produces `req_gnt` and `tbuf_rd_en` in cycle t+1 when it wins.
- Throughput:
  - Up to one grant per cycle overall, across different requesters.
  - One requester alone is granted at most every 2 cycles, because of the `gnt_q` mask.
- Return latency: `tbuf_rd_valid` in cycle t gives `req_rd_valid` in cycle t+1.
- Fairness: with all requests held, grants rotate strictly 0,1,2,3,0,… from reset.

## Test plan
- Single request: after reset, requester 2 requests addr 0x10; the buffer returns 0xAB..AB two cycles after `tbuf_rd_en`.
  - Expect `req_gnt=0100` and `tbuf_rd_addr=0x10` one cycle after the request.
  - Expect `req_rd_valid=0100` with data 0xAB..AB one cycle after `tbuf_rd_valid`.
- Fairness: all four requesters hold requests with re-requesting after each grant.
  - Grant order is 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Each return is routed to the matching requester in issue order.
- Backpressure: the buffer withholds `tbuf_rd_valid` while 5 requests are pending.
  - Exactly 4 grants occur, then `cnt=4` and no grant.
  - The first `tbuf_rd_valid` returns to the first grantee.
  - The fifth grant appears in the cycle after the pop edge, not in the same cycle as the pop.
- Simultaneous push and pop: grant and return in the same cycle with `cnt=2`.
  - `cnt` stays 2 and `busy` stays 1.
  - The return goes to the oldest ID.
- Spurious return: `tbuf_rd_valid` pulses when `cnt=0`.
  - `err_spurious=1` and stays set.
  - `req_rd_valid` stays 0.
- Mid-operation reset: assert `rst_n=0` for 1 cycle with 3 reads outstanding.
  - All outputs return to their reset values.
  - A subsequent stray return sets `err_spurious`.
  - The next grant goes to requester 0 first.
